// File: rtl/wb_commit_unit.sv
// -----------------------------------------------------------------------------
// wb_commit_unit
//
// Write-back sink for the 5-stage pipeline. It takes the register, accumulator
// and memory-write controls from the write-back stage and commits them into
// architectural state:
//   * a 32 x DATA_W register file with two bypassed read ports (r0 reads 0),
//   * the accumulator, bypassed on acc_out,
//   * a SB_DEPTH-entry store buffer that drains to data memory and forwards
//     buffered store data to a probing load address.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   reg_write_enable/addr/data    register commit from write-back
//   acc_write_enable/accum_value  accumulator commit from write-back
//   mem_write_enable/addr/data    store push into the buffer
//   rs_addr, rt_addr -> rs_data, rt_data   decode-stage reads (combinational)
//   acc_out                       accumulator value (combinational, bypassed)
//   ld_addr -> ld_hit, ld_data    store-to-load forwarding probe
//   dm_wr_valid/ready/addr/data   data-memory write port (head of buffer)
//   sb_full, sb_empty             buffer occupancy flags (from registered count)
//   sb_overflow                   sticky flag: a store was dropped while full
//
// Handshake (data-memory write port): dm_wr_valid is high whenever the buffer
// holds at least one store; dm_wr_addr/dm_wr_data show the head entry and stay
// stable while dm_wr_valid & ~dm_wr_ready. A store transfers on every rising
// edge where dm_wr_valid & dm_wr_ready, after which the next entry is shown.
// -----------------------------------------------------------------------------
module wb_commit_unit #(
   parameter int DATA_W     = 8,
   parameter int REG_ADDR_W = 5,
   parameter int MEM_ADDR_W = 8,
   parameter int SB_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   // register commit
   input  logic                  reg_write_enable,
   input  logic [REG_ADDR_W-1:0] reg_write_addr,
   input  logic [DATA_W-1:0]     reg_write_data,
   // accumulator commit
   input  logic                  acc_write_enable,
   input  logic [DATA_W-1:0]     accum_value,
   // store push
   input  logic                  mem_write_enable,
   input  logic [MEM_ADDR_W-1:0] mem_write_addr,
   input  logic [DATA_W-1:0]     mem_write_data,
   // decode-stage reads
   input  logic [REG_ADDR_W-1:0] rs_addr,
   input  logic [REG_ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0]     rs_data,
   output logic [DATA_W-1:0]     rt_data,
   output logic [DATA_W-1:0]     acc_out,
   // load forwarding probe
   input  logic [MEM_ADDR_W-1:0] ld_addr,
   output logic                  ld_hit,
   output logic [DATA_W-1:0]     ld_data,
   // data-memory write port
   output logic                  dm_wr_valid,
   input  logic                  dm_wr_ready,
   output logic [MEM_ADDR_W-1:0] dm_wr_addr,
   output logic [DATA_W-1:0]     dm_wr_data,
   // buffer status
   output logic                  sb_full,
   output logic                  sb_empty,
   output logic                  sb_overflow
);

   localparam int NUM_REGS = 1 << REG_ADDR_W;
   localparam int PTR_W    = $clog2(SB_DEPTH);
   localparam int CNT_W    = PTR_W + 1;

   localparam logic [CNT_W-1:0] SB_DEPTH_C = CNT_W'(SB_DEPTH);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [DATA_W-1:0]     regs_q    [NUM_REGS];
   logic [DATA_W-1:0]     acc_q;

   logic [MEM_ADDR_W-1:0] sb_addr_q [SB_DEPTH];
   logic [DATA_W-1:0]     sb_data_q [SB_DEPTH];
   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  overflow_q, overflow_d;

   logic                  reg_we;
   logic                  push;
   logic                  pop;

   // ---------------------------------------------------------------------------
   // Register file and accumulator reads
   // ---------------------------------------------------------------------------
   // Writes to r0 are dropped here so r0 never needs a special read path other
   // than forcing zero, and so the bypass below never fires for index 0.
   assign reg_we = reg_write_enable && (reg_write_addr != '0);

   always_comb begin
      rs_data = regs_q[rs_addr];
      if (rs_addr == '0) begin
         rs_data = '0;
      end else if (reg_we && (rs_addr == reg_write_addr)) begin
         rs_data = reg_write_data;
      end
   end

   always_comb begin
      rt_data = regs_q[rt_addr];
      if (rt_addr == '0) begin
         rt_data = '0;
      end else if (reg_we && (rt_addr == reg_write_addr)) begin
         rt_data = reg_write_data;
      end
   end

   assign acc_out = acc_write_enable ? accum_value : acc_q;

   // ---------------------------------------------------------------------------
   // Store buffer control
   // ---------------------------------------------------------------------------
   assign sb_empty    = (count_q == '0);
   assign sb_full     = (count_q == SB_DEPTH_C);
   assign sb_overflow = overflow_q;

   assign dm_wr_valid = ~sb_empty;
   assign dm_wr_addr  = sb_addr_q[head_q];
   assign dm_wr_data  = sb_data_q[head_q];

   assign pop  = dm_wr_valid & dm_wr_ready;
   // A store arriving while full only fits if the head leaves on the same edge;
   // the freed slot is the one the tail pointer is about to reuse.
   assign push = mem_write_enable & (~sb_full | pop);

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      if (push) begin
         tail_d = tail_q + 1'b1;
      end
      if (pop) begin
         head_d = head_q + 1'b1;
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (mem_write_enable && !push) begin
         overflow_d = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Store-to-load forwarding
   // ---------------------------------------------------------------------------
   // Entries are walked oldest to youngest starting at the head, so a later
   // match overrides an earlier one and the youngest matching store wins.
   // Only registered entries are searched; a store being pushed this cycle
   // becomes visible on the next cycle.
   logic [PTR_W-1:0] fwd_idx;

   always_comb begin
      ld_hit  = 1'b0;
      ld_data = '0;
      fwd_idx = head_q;
      for (int i = 0; i < SB_DEPTH; i++) begin
         fwd_idx = head_q + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && (sb_addr_q[fwd_idx] == ld_addr)) begin
            ld_hit  = 1'b1;
            ld_data = sb_data_q[fwd_idx];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Sequential state
   // ---------------------------------------------------------------------------
   // Reset wins over every write, push and pop sampled on the same edge, so a
   // buffer that was mid-drain comes out of reset empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= '0;
         end
         acc_q <= '0;
         for (int e = 0; e < SB_DEPTH; e++) begin
            sb_addr_q[e] <= '0;
            sb_data_q[e] <= '0;
         end
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (reg_we) begin
            regs_q[reg_write_addr] <= reg_write_data;
         end
         if (acc_write_enable) begin
            acc_q <= accum_value;
         end
         if (push) begin
            sb_addr_q[tail_q] <= mem_write_addr;
            sb_data_q[tail_q] <= mem_write_data;
         end
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_wb_commit_unit.sv
// -----------------------------------------------------------------------------
// tb_wb_commit_unit
//
// Directed bench for wb_commit_unit. Inputs are driven 1 ns after each rising
// edge and outputs are compared a further 1 ns later, well clear of the edge.
// Each scenario task leaves the bench at the "just after an edge" point.
// -----------------------------------------------------------------------------
module tb_wb_commit_unit;

   localparam int DATA_W     = 8;
   localparam int REG_ADDR_W = 5;
   localparam int MEM_ADDR_W = 8;
   localparam int SB_DEPTH   = 4;

   // clock / reset
   logic clk;
   logic rst;

   logic                  reg_write_enable;
   logic [REG_ADDR_W-1:0] reg_write_addr;
   logic [DATA_W-1:0]     reg_write_data;
   logic                  acc_write_enable;
   logic [DATA_W-1:0]     accum_value;
   logic                  mem_write_enable;
   logic [MEM_ADDR_W-1:0] mem_write_addr;
   logic [DATA_W-1:0]     mem_write_data;
   logic [REG_ADDR_W-1:0] rs_addr;
   logic [REG_ADDR_W-1:0] rt_addr;
   logic [DATA_W-1:0]     rs_data;
   logic [DATA_W-1:0]     rt_data;
   logic [DATA_W-1:0]     acc_out;
   logic [MEM_ADDR_W-1:0] ld_addr;
   logic                  ld_hit;
   logic [DATA_W-1:0]     ld_data;
   logic                  dm_wr_valid;
   logic                  dm_wr_ready;
   logic [MEM_ADDR_W-1:0] dm_wr_addr;
   logic [DATA_W-1:0]     dm_wr_data;
   logic                  sb_full;
   logic                  sb_empty;
   logic                  sb_overflow;

   int vec_cnt = 0;
   int err_cnt = 0;

   // scoreboard of stores expected on the data-memory port, {addr, data}
   logic [MEM_ADDR_W+DATA_W-1:0] exp_q[$];

   wb_commit_unit #(
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W),
      .MEM_ADDR_W (MEM_ADDR_W),
      .SB_DEPTH   (SB_DEPTH)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .reg_write_enable (reg_write_enable),
      .reg_write_addr   (reg_write_addr),
      .reg_write_data   (reg_write_data),
      .acc_write_enable (acc_write_enable),
      .accum_value      (accum_value),
      .mem_write_enable (mem_write_enable),
      .mem_write_addr   (mem_write_addr),
      .mem_write_data   (mem_write_data),
      .rs_addr          (rs_addr),
      .rt_addr          (rt_addr),
      .rs_data          (rs_data),
      .rt_data          (rt_data),
      .acc_out          (acc_out),
      .ld_addr          (ld_addr),
      .ld_hit           (ld_hit),
      .ld_data          (ld_data),
      .dm_wr_valid      (dm_wr_valid),
      .dm_wr_ready      (dm_wr_ready),
      .dm_wr_addr       (dm_wr_addr),
      .dm_wr_data       (dm_wr_data),
      .sb_full          (sb_full),
      .sb_empty         (sb_empty),
      .sb_overflow      (sb_overflow)
   );

   // ---------------------------------------------------------------------------
   // Clock and watchdog
   // ---------------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------------
   // Driver tasks / scenarios
   // ---------------------------------------------------------------------------
   task automatic drive_idle();
      reg_write_enable = 1'b0;
      reg_write_addr   = '0;
      reg_write_data   = '0;
      acc_write_enable = 1'b0;
      accum_value      = '0;
      mem_write_enable = 1'b0;
      mem_write_addr   = '0;
      mem_write_data   = '0;
      rs_addr          = '0;
      rt_addr          = '0;
      ld_addr          = '0;
      dm_wr_ready      = 1'b0;
   endtask

   task automatic test_reset();
      rs_addr = 5'd3;
      rt_addr = 5'd0;
      #1;
      vec_cnt++; if (rs_data !== 8'h00) begin err_cnt++; $display("FAIL reset_rs_data got %h exp 00", rs_data); end
      vec_cnt++; if (rt_data !== 8'h00) begin err_cnt++; $display("FAIL reset_rt_data got %h exp 00", rt_data); end
      vec_cnt++; if (acc_out !== 8'h00) begin err_cnt++; $display("FAIL reset_acc_out got %h exp 00", acc_out); end
      vec_cnt++; if (dm_wr_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_dm_wr_valid got %b exp 0", dm_wr_valid); end
      vec_cnt++; if (sb_empty !== 1'b1) begin err_cnt++; $display("FAIL reset_sb_empty got %b exp 1", sb_empty); end
      vec_cnt++; if (sb_full !== 1'b0) begin err_cnt++; $display("FAIL reset_sb_full got %b exp 0", sb_full); end
      vec_cnt++; if (sb_overflow !== 1'b0) begin err_cnt++; $display("FAIL reset_sb_overflow got %b exp 0", sb_overflow); end
      vec_cnt++; if ({ld_hit, ld_data} !== 9'h000) begin err_cnt++; $display("FAIL reset_ld got hit=%b data=%h exp 0/00", ld_hit, ld_data); end
      tick();
   endtask

   task automatic test_regfile();
      // same-cycle bypass on both ports
      reg_write_enable = 1'b1; reg_write_addr = 5'd5; reg_write_data = 8'hA7;
      rs_addr = 5'd5; rt_addr = 5'd5;
      #1;
      vec_cnt++; if (rs_data !== 8'hA7) begin err_cnt++; $display("FAIL rf_bypass_rs got %h exp a7", rs_data); end
      vec_cnt++; if (rt_data !== 8'hA7) begin err_cnt++; $display("FAIL rf_bypass_rt got %h exp a7", rt_data); end
      tick();
      reg_write_enable = 1'b0; reg_write_data = 8'h00;
      #1;
      vec_cnt++; if (rs_data !== 8'hA7) begin err_cnt++; $display("FAIL rf_array_rs got %h exp a7", rs_data); end
      // r0 write ignored, no bypass
      reg_write_enable = 1'b1; reg_write_addr = 5'd0; reg_write_data = 8'hFF;
      rs_addr = 5'd0; rt_addr = 5'd5;
      #1;
      vec_cnt++; if (rs_data !== 8'h00) begin err_cnt++; $display("FAIL rf_r0_bypass got %h exp 00", rs_data); end
      vec_cnt++; if (rt_data !== 8'hA7) begin err_cnt++; $display("FAIL rf_r5_hold got %h exp a7", rt_data); end
      tick();
      reg_write_enable = 1'b0;
      #1;
      vec_cnt++; if (rs_data !== 8'h00) begin err_cnt++; $display("FAIL rf_r0_after got %h exp 00", rs_data); end
      // independent ports: rs bypassed, rt from array
      reg_write_enable = 1'b1; reg_write_addr = 5'd9; reg_write_data = 8'h5C;
      rs_addr = 5'd9; rt_addr = 5'd5;
      #1;
      vec_cnt++; if (rs_data !== 8'h5C) begin err_cnt++; $display("FAIL rf_r9_bypass got %h exp 5c", rs_data); end
      vec_cnt++; if (rt_data !== 8'hA7) begin err_cnt++; $display("FAIL rf_r5_other_port got %h exp a7", rt_data); end
      tick();
      reg_write_enable = 1'b0; rt_addr = 5'd9;
      #1;
      vec_cnt++; if (rt_data !== 8'h5C) begin err_cnt++; $display("FAIL rf_r9_array got %h exp 5c", rt_data); end
      tick();
   endtask

   task automatic test_acc();
      acc_write_enable = 1'b0; accum_value = 8'h3C;
      #1;
      vec_cnt++; if (acc_out !== 8'h00) begin err_cnt++; $display("FAIL acc_no_enable got %h exp 00", acc_out); end
      acc_write_enable = 1'b1;
      #1;
      vec_cnt++; if (acc_out !== 8'h3C) begin err_cnt++; $display("FAIL acc_bypass got %h exp 3c", acc_out); end
      tick();
      acc_write_enable = 1'b0; accum_value = 8'h99;
      #1;
      vec_cnt++; if (acc_out !== 8'h3C) begin err_cnt++; $display("FAIL acc_hold got %h exp 3c", acc_out); end
      tick();
   endtask

   task automatic test_store_fwd();
      dm_wr_ready = 1'b0;
      mem_write_enable = 1'b1; mem_write_addr = 8'h10; mem_write_data = 8'h11; ld_addr = 8'h10;
      #1;
      vec_cnt++; if (ld_hit !== 1'b0) begin err_cnt++; $display("FAIL fwd_push_invisible got %b exp 0", ld_hit); end
      vec_cnt++; if (dm_wr_valid !== 1'b0) begin err_cnt++; $display("FAIL st_valid_before got %b exp 0", dm_wr_valid); end
      tick();
      mem_write_addr = 8'h20; mem_write_data = 8'h22;
      #1;
      vec_cnt++; if ({dm_wr_valid, dm_wr_addr, dm_wr_data} !== {1'b1, 8'h10, 8'h11}) begin err_cnt++; $display("FAIL st_head_first got v=%b a=%h d=%h exp 1/10/11", dm_wr_valid, dm_wr_addr, dm_wr_data); end
      tick();
      mem_write_addr = 8'h10; mem_write_data = 8'h33;
      #1;
      // (10,33) is being pushed this cycle and must not win yet
      vec_cnt++; if ({ld_hit, ld_data} !== {1'b1, 8'h11}) begin err_cnt++; $display("FAIL fwd_old_match got hit=%b data=%h exp 1/11", ld_hit, ld_data); end
      tick();
      mem_write_enable = 1'b0;
      #1;
      vec_cnt++; if ({ld_hit, ld_data} !== {1'b1, 8'h33}) begin err_cnt++; $display("FAIL fwd_youngest got hit=%b data=%h exp 1/33", ld_hit, ld_data); end
      vec_cnt++; if ({dm_wr_valid, dm_wr_addr, dm_wr_data} !== {1'b1, 8'h10, 8'h11}) begin err_cnt++; $display("FAIL st_head_held got v=%b a=%h d=%h exp 1/10/11", dm_wr_valid, dm_wr_addr, dm_wr_data); end
      vec_cnt++; if ({sb_full, sb_empty} !== 2'b00) begin err_cnt++; $display("FAIL st_flags_3 got full=%b empty=%b exp 0/0", sb_full, sb_empty); end
      ld_addr = 8'h20;
      #1;
      vec_cnt++; if ({ld_hit, ld_data} !== {1'b1, 8'h22}) begin err_cnt++; $display("FAIL fwd_addr20 got hit=%b data=%h exp 1/22", ld_hit, ld_data); end
      ld_addr = 8'h30;
      #1;
      vec_cnt++; if ({ld_hit, ld_data} !== {1'b0, 8'h00}) begin err_cnt++; $display("FAIL fwd_miss got hit=%b data=%h exp 0/00", ld_hit, ld_data); end
      tick();
   endtask

   task automatic test_overflow();
      // buffer holds (10,11),(20,22),(10,33); fourth entry fills it
      mem_write_enable = 1'b1; mem_write_addr = 8'h40; mem_write_data = 8'h44;
      tick();
      mem_write_addr = 8'h50; mem_write_data = 8'h55;
      #1;
      vec_cnt++; if (sb_full !== 1'b1) begin err_cnt++; $display("FAIL ovf_full got %b exp 1", sb_full); end
      vec_cnt++; if (sb_overflow !== 1'b0) begin err_cnt++; $display("FAIL ovf_not_yet got %b exp 0", sb_overflow); end
      tick();
      mem_write_enable = 1'b0; ld_addr = 8'h50;
      #1;
      vec_cnt++; if (sb_overflow !== 1'b1) begin err_cnt++; $display("FAIL ovf_set got %b exp 1", sb_overflow); end
      vec_cnt++; if (sb_full !== 1'b1) begin err_cnt++; $display("FAIL ovf_still_full got %b exp 1", sb_full); end
      vec_cnt++; if ({dm_wr_addr, dm_wr_data} !== {8'h10, 8'h11}) begin err_cnt++; $display("FAIL ovf_head got a=%h d=%h exp 10/11", dm_wr_addr, dm_wr_data); end
      vec_cnt++; if (ld_hit !== 1'b0) begin err_cnt++; $display("FAIL ovf_dropped_visible got %b exp 0", ld_hit); end
      // push while full with a simultaneous pop is accepted
      mem_write_enable = 1'b1; mem_write_addr = 8'h60; mem_write_data = 8'h66; dm_wr_ready = 1'b1;
      #1;
      vec_cnt++; if ({dm_wr_valid, dm_wr_addr} !== {1'b1, 8'h10}) begin err_cnt++; $display("FAIL ovf_pop_head got v=%b a=%h exp 1/10", dm_wr_valid, dm_wr_addr); end
      tick();
      mem_write_enable = 1'b0; dm_wr_ready = 1'b0; ld_addr = 8'h60;
      #1;
      vec_cnt++; if (sb_full !== 1'b1) begin err_cnt++; $display("FAIL ovf_swap_full got %b exp 1", sb_full); end
      vec_cnt++; if ({dm_wr_addr, dm_wr_data} !== {8'h20, 8'h22}) begin err_cnt++; $display("FAIL ovf_head_adv got a=%h d=%h exp 20/22", dm_wr_addr, dm_wr_data); end
      vec_cnt++; if ({ld_hit, ld_data} !== {1'b1, 8'h66}) begin err_cnt++; $display("FAIL ovf_swap_fwd got hit=%b data=%h exp 1/66", ld_hit, ld_data); end
      ld_addr = 8'h10;
      #1;
      vec_cnt++; if ({ld_hit, ld_data} !== {1'b1, 8'h33}) begin err_cnt++; $display("FAIL ovf_fwd_remaining got hit=%b data=%h exp 1/33", ld_hit, ld_data); end
      tick();
   endtask

   task automatic test_drain();
      logic [3:0] ready_pat;
      int cyc;
      ready_pat = 4'b1101;  // ready per cycle: 1,0,1,1 then stays 1
      exp_q = {};
      exp_q.push_back({8'h20, 8'h22});
      exp_q.push_back({8'h10, 8'h33});
      exp_q.push_back({8'h40, 8'h44});
      exp_q.push_back({8'h60, 8'h66});
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 12) begin
         dm_wr_ready = (cyc < 4) ? ready_pat[cyc] : 1'b1;
         #1;
         vec_cnt++;
         if ({dm_wr_valid, dm_wr_addr, dm_wr_data} !== {1'b1, exp_q[0]}) begin
            err_cnt++;
            $display("FAIL drain_order cyc=%0d got v=%b a=%h d=%h exp 1/%h/%h", cyc, dm_wr_valid, dm_wr_addr, dm_wr_data, exp_q[0][15:8], exp_q[0][7:0]);
         end
         if (dm_wr_ready) void'(exp_q.pop_front());
         tick();
         cyc++;
      end
      vec_cnt++; if (exp_q.size() != 0) begin err_cnt++; $display("FAIL drain_timeout got %0d left exp 0", exp_q.size()); end
      dm_wr_ready = 1'b0;
      #1;
      vec_cnt++; if ({dm_wr_valid, sb_empty} !== 2'b01) begin err_cnt++; $display("FAIL drain_empty got v=%b empty=%b exp 0/1", dm_wr_valid, sb_empty); end
      vec_cnt++; if (sb_overflow !== 1'b1) begin err_cnt++; $display("FAIL drain_ovf_sticky got %b exp 1", sb_overflow); end
      tick();
   endtask

   task automatic test_back_to_back();
      dm_wr_ready = 1'b1;
      mem_write_enable = 1'b1; mem_write_addr = 8'hA0; mem_write_data = 8'h0A;
      #1;
      vec_cnt++; if (dm_wr_valid !== 1'b0) begin err_cnt++; $display("FAIL b2b_c0_valid got %b exp 0", dm_wr_valid); end
      tick();
      mem_write_addr = 8'hA1; mem_write_data = 8'h1A;
      #1;
      vec_cnt++; if ({dm_wr_valid, dm_wr_addr, dm_wr_data} !== {1'b1, 8'hA0, 8'h0A}) begin err_cnt++; $display("FAIL b2b_c1 got v=%b a=%h d=%h exp 1/a0/0a", dm_wr_valid, dm_wr_addr, dm_wr_data); end
      tick();
      mem_write_addr = 8'hA2; mem_write_data = 8'h2A;
      #1;
      vec_cnt++; if ({dm_wr_valid, dm_wr_addr, dm_wr_data} !== {1'b1, 8'hA1, 8'h1A}) begin err_cnt++; $display("FAIL b2b_c2 got v=%b a=%h d=%h exp 1/a1/1a", dm_wr_valid, dm_wr_addr, dm_wr_data); end
      tick();
      mem_write_enable = 1'b0;
      #1;
      vec_cnt++; if ({dm_wr_valid, dm_wr_addr, dm_wr_data} !== {1'b1, 8'hA2, 8'h2A}) begin err_cnt++; $display("FAIL b2b_c3 got v=%b a=%h d=%h exp 1/a2/2a", dm_wr_valid, dm_wr_addr, dm_wr_data); end
      vec_cnt++; if ({sb_full, sb_empty} !== 2'b00) begin err_cnt++; $display("FAIL b2b_one_entry got full=%b empty=%b exp 0/0", sb_full, sb_empty); end
      tick();
      #1;
      vec_cnt++; if ({dm_wr_valid, sb_empty} !== 2'b01) begin err_cnt++; $display("FAIL b2b_done got v=%b empty=%b exp 0/1", dm_wr_valid, sb_empty); end
      dm_wr_ready = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_drain();
      dm_wr_ready = 1'b0;
      mem_write_enable = 1'b1; mem_write_addr = 8'h70; mem_write_data = 8'h77;
      tick();
      mem_write_addr = 8'h71; mem_write_data = 8'h78;
      tick();
      mem_write_enable = 1'b0;
      #1;
      vec_cnt++; if ({dm_wr_valid, sb_empty} !== 2'b10) begin err_cnt++; $display("FAIL rstd_pending got v=%b empty=%b exp 1/0", dm_wr_valid, sb_empty); end
      // reset alongside a push, register write and accumulator write
      rst = 1'b1;
      mem_write_enable = 1'b1; mem_write_addr = 8'h72; mem_write_data = 8'h79;
      reg_write_enable = 1'b1; reg_write_addr = 5'd7; reg_write_data = 8'h12;
      acc_write_enable = 1'b1; accum_value = 8'h55;
      tick();
      rst = 1'b0;
      mem_write_enable = 1'b0; reg_write_enable = 1'b0; acc_write_enable = 1'b0;
      rs_addr = 5'd5; rt_addr = 5'd7; ld_addr = 8'h70;
      #1;
      vec_cnt++; if (dm_wr_valid !== 1'b0) begin err_cnt++; $display("FAIL rstd_valid got %b exp 0", dm_wr_valid); end
      vec_cnt++; if (sb_empty !== 1'b1) begin err_cnt++; $display("FAIL rstd_empty got %b exp 1", sb_empty); end
      vec_cnt++; if (sb_overflow !== 1'b0) begin err_cnt++; $display("FAIL rstd_ovf_clear got %b exp 0", sb_overflow); end
      vec_cnt++; if (acc_out !== 8'h00) begin err_cnt++; $display("FAIL rstd_acc got %h exp 00", acc_out); end
      vec_cnt++; if ({rs_data, rt_data} !== 16'h0000) begin err_cnt++; $display("FAIL rstd_regs got rs=%h rt=%h exp 00/00", rs_data, rt_data); end
      vec_cnt++; if (ld_hit !== 1'b0) begin err_cnt++; $display("FAIL rstd_fwd got %b exp 0", ld_hit); end
      tick();
   endtask

   // ---------------------------------------------------------------------------
   // Sequence and report
   // ---------------------------------------------------------------------------
   initial begin
      drive_idle();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;

      test_reset();
      test_regfile();
      test_acc();
      test_store_fwd();
      test_overflow();
      test_drain();
      test_back_to_back();
      test_reset_mid_drain();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/wb_commit_unit.md
# wb_commit_unit

Write-back sink for the 5-stage pipeline. Consumes the register, accumulator and memory write controls produced by the write-back stage each cycle and commits them into architectural state. That state is a 32×8 register file with two bypassed read ports, the accumulator, and a 4-entry store buffer that drains to data memory through a valid/ready handshake with store-to-load forwarding. It sits between the write-back stage and the decode-stage register reads / data-memory write port.

## Interface
- DATA_W, 8, data width of registers, accumulator and memory data
- REG_ADDR_W, 5, register index width (32 registers)
- MEM_ADDR_W, 8, data-memory address width
- SB_DEPTH, 4, store-buffer entries (power of two, ≥2)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- reg_write_enable  in  1  commit reg_write_data to reg_write_addr
- reg_write_addr  in  REG_ADDR_W  destination register
- reg_write_data  in  DATA_W  register write data
- acc_write_enable  in  1  commit accum_value to the accumulator
- accum_value  in  DATA_W  new accumulator value
- mem_write_enable  in  1  push a store into the buffer
- mem_write_addr  in  MEM_ADDR_W  store address
- mem_write_data  in  DATA_W  store data
- rs_addr, rt_addr  in  REG_ADDR_W  decode-stage read indices
- rs_data, rt_data  out  DATA_W  read data (combinational, bypassed)
- acc_out  out  DATA_W  accumulator (bypassed)
- ld_addr  in  MEM_ADDR_W  load address probed for forwarding
- ld_hit  out  1  ld_addr matches a buffered store
- ld_data  out  DATA_W  data of youngest matching store
- dm_wr_valid  out  1  head store presented to data memory
- dm_wr_ready  in  1  data memory accepts head store
- dm_wr_addr  out  MEM_ADDR_W  head store address
- dm_wr_data  out  DATA_W  head store data
- sb_full  out  1  buffer holds SB_DEPTH entries; pipeline must stall stores
- sb_empty  out  1  buffer holds 0 entries
- sb_overflow  out  1  sticky: a store was dropped

## Operation
- Register 0 is hardwired: reads return 0, writes are ignored, no bypass for index 0.
- Register write: on edge with reg_write_enable, regfile[reg_write_addr] <= reg_write_data.
- Read bypass: if reg_write_enable and the read index equals reg_write_addr (≠0), that port returns reg_write_data in the same cycle. Otherwise it returns the array value.
- Accumulator: on edge with acc_write_enable, acc <= accum_value. acc_out returns accum_value while acc_write_enable is high, else acc.
- Store buffer is a circular FIFO with head/tail pointers wrapping mod SB_DEPTH and a count of 0..SB_DEPTH.
- pop = dm_wr_valid & dm_wr_ready.
- push = mem_write_enable & (count<SB_DEPTH | pop). A push while full is accepted only when a pop occurs in the same cycle.
- mem_write_enable while full with no pop: the store is dropped, count is unchanged, and sb_overflow is set. sb_overflow clears only on rst.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- dm_wr_valid = ~sb_empty. dm_wr_addr/dm_wr_data are the head entry and are held stable while valid & ~ready.
- Forwarding: ld_hit=1 when any valid entry's address equals ld_addr. ld_data is the data of the youngest such entry. A store pushed in the current cycle is not visible until the next cycle. ld_data=0 when ld_hit=0.

## Timing
- Reset values: all registers 0, acc 0, count 0, pointers 0, sb_empty 1, sb_full 0, dm_wr_valid 0, sb_overflow 0. rs_data/rt_data/acc_out/ld_data follow from that state.
- Reset mid-drain: dm_wr_valid is 0 the cycle after rst is sampled. Buffered stores are discarded. rst has priority over every write and push in the same cycle.
- Register/accumulator writes: 0-cycle visibility via bypass, 1-cycle visibility via the array.
- Store latency: pushed at edge N, dm_wr_valid and head data valid from cycle N+1 when the buffer was empty. One pop per cycle maximum, so sustained throughput is 1 store/cycle.
- sb_full/sb_empty are derived from the registered count and update the cycle after the push/pop edge.

## Test plan
- Reset, then read rs_addr=3, rt_addr=0 -> rs_data=0, rt_data=0, acc_out=0, dm_wr_valid=0, sb_empty=1.
- Write r5=0xA7 with rs_addr=5 in the same cycle -> rs_data=0xA7 that cycle and the next. Write r0=0xFF -> read of r0 stays 0.
- acc_write_enable with accum_value=0x3C -> acc_out=0x3C same cycle; it holds after enable drops.
- Push stores (0x10,0x11),(0x20,0x22),(0x10,0x33) with dm_wr_ready=0 -> dm_wr_valid=1, dm_wr_addr=0x10, dm_wr_data=0x11 held. ld_addr=0x10 -> ld_hit=1, ld_data=0x33.
- Fill 4 entries with ready=0, push a 5th -> sb_full=1, sb_overflow=1, count stays 4. Then push with ready=1 in one cycle -> accepted, head advances, sb_full stays 1.
- Drain with ready toggling 1,0,1,1 -> stores emerge in FIFO order with no duplicates. Assert rst with 2 entries pending -> dm_wr_valid=0 next cycle and sb_empty=1.
